// File: rtl/rom_matrix_loader.sv
// Fetches one 2x2 byte matrix per ROM channel from a selected bank and hands both
// matrices downstream with a valid/ready handshake.
module rom_matrix_loader (
    input  logic        I_sys_clk,
    input  logic        I_sys_rstn,
    input  logic        I_start,
    input  logic        I_bank,
    output logic        O_busy,
    output logic        O_rom_ena,
    output logic [2:0]  O_addr,
    input  logic [7:0]  I_data_from_channelA,
    input  logic [7:0]  I_data_from_channelB,
    input  logic        I_two_channel_data_valid,
    output logic [31:0] O_mat_a,
    output logic [31:0] O_mat_b,
    output logic        O_mat_valid,
    input  logic        I_mat_ready,
    output logic        O_done
);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StHold} state_e;

    state_e      state_q;
    logic        bank_q;
    logic [1:0]  issue_cnt_q;
    logic [1:0]  beat_cnt_q;
    logic        rom_ena_q;
    logic [2:0]  addr_q;
    logic [31:0] mat_a_q;
    logic [31:0] mat_b_q;
    logic        mat_valid_q;
    logic        done_q;

    always_ff @(posedge I_sys_clk) begin
        if (!I_sys_rstn) begin
            state_q     <= StIdle;
            bank_q      <= 1'b0;
            issue_cnt_q <= 2'd0;
            beat_cnt_q  <= 2'd0;
            rom_ena_q   <= 1'b0;
            addr_q      <= 3'd0;
            mat_a_q     <= 32'd0;
            mat_b_q     <= 32'd0;
            mat_valid_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;

            // Returned beats land in slot beat_cnt only while a fetch is in flight.
            if ((state_q == StRead || state_q == StDrain) && I_two_channel_data_valid) begin
                mat_a_q[{beat_cnt_q, 3'b000} +: 8] <= I_data_from_channelA;
                mat_b_q[{beat_cnt_q, 3'b000} +: 8] <= I_data_from_channelB;
                beat_cnt_q <= beat_cnt_q + 2'd1;
            end

            case (state_q)
                StIdle: begin
                    if (I_start) begin
                        bank_q      <= I_bank;
                        rom_ena_q   <= 1'b1;
                        addr_q      <= {I_bank, 2'b00};
                        issue_cnt_q <= 2'd0;
                        beat_cnt_q  <= 2'd0;
                        state_q     <= StRead;
                    end
                end
                StRead: begin
                    if (issue_cnt_q == 2'd3) begin
                        rom_ena_q <= 1'b0;
                        state_q   <= StDrain;
                    end else begin
                        issue_cnt_q <= issue_cnt_q + 2'd1;
                        addr_q      <= {bank_q, issue_cnt_q + 2'd1};
                    end
                end
                StDrain: begin
                    if (I_two_channel_data_valid && beat_cnt_q == 2'd3) begin
                        mat_valid_q <= 1'b1;
                        state_q     <= StHold;
                    end
                end
                StHold: begin
                    if (mat_valid_q && I_mat_ready) begin
                        mat_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign O_busy      = (state_q != StIdle);
    assign O_rom_ena   = rom_ena_q;
    assign O_addr      = addr_q;
    assign O_mat_a     = mat_a_q;
    assign O_mat_b     = mat_b_q;
    assign O_mat_valid = mat_valid_q;
    assign O_done      = done_q;

endmodule

// File: tb/tb_rom_matrix_loader.sv
// Bench for rom_matrix_loader: registered two-channel ROM model, directed scenarios,
// then randomized loads checked against matrices packed straight from the ROM arrays.
module tb_rom_matrix_loader;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        bank = 1'b0;
    logic        ready = 1'b0;
    logic        spur = 1'b0;
    logic        busy, ena, mat_valid, done, valid;
    logic [2:0]  addr;
    logic [7:0]  da, db;
    logic [31:0] ma, mb;

    logic [7:0]  rom_a [8];
    logic [7:0]  rom_b [8];
    logic        rom_valid;
    logic [7:0]  rom_da, rom_db;

    int checks = 0;
    int errors = 0;
    int ena_cycles = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    rom_matrix_loader dut (
        .I_sys_clk                (clk),
        .I_sys_rstn               (rstn),
        .I_start                  (start),
        .I_bank                   (bank),
        .O_busy                   (busy),
        .O_rom_ena                (ena),
        .O_addr                   (addr),
        .I_data_from_channelA     (da),
        .I_data_from_channelB     (db),
        .I_two_channel_data_valid (valid),
        .O_mat_a                  (ma),
        .O_mat_b                  (mb),
        .O_mat_valid              (mat_valid),
        .I_mat_ready              (ready),
        .O_done                   (done)
    );

    // ROM: one-cycle registered data/valid; spur injects a stray beat with junk data.
    always @(posedge clk) begin
        rom_valid <= ena;
        rom_da    <= rom_a[addr];
        rom_db    <= rom_b[addr];
    end
    assign valid = rom_valid | spur;
    assign da    = spur ? 8'hEE : rom_da;
    assign db    = spur ? 8'hDD : rom_db;

    always @(posedge clk) begin
        if (ena === 1'b1) ena_cycles <= ena_cycles + 1;
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] pack_a(input bit b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = rom_a[b*4 + i];
        return m;
    endfunction

    function automatic logic [31:0] pack_b(input bit b);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = rom_b[b*4 + i];
        return m;
    endfunction

    // Runs one load from the edge that samples start through the handshake edge.
    // poke keeps start high throughout, which must have no effect.
    task automatic do_load(input bit b, input int rdly, input bit poke);
        logic [31:0] ea, eb;
        int e0;
        ea = pack_a(b);
        eb = pack_b(b);
        e0 = ena_cycles;
        start = 1'b1;
        bank  = b;
        step();
        for (int i = 0; i < 4; i++) begin
            chk("ena_read", ena, 1);
            chk("addr_read", addr, b*4 + i);
            chk("busy_read", busy, 1);
            start = poke;
            bank  = 1'($urandom_range(0, 1));
            step();
        end
        chk("ena_drain", ena, 0);
        chk("addr_hold", addr, b*4 + 3);
        chk("valid_early", mat_valid, 0);
        step();
        chk("valid_e5", mat_valid, 1);
        chk("mat_a", ma, ea);
        chk("mat_b", mb, eb);
        for (int k = 0; k < rdly; k++) begin
            ready = 1'b0;
            step();
            chk("valid_bp", mat_valid, 1);
            chk("mat_a_bp", ma, ea);
            chk("mat_b_bp", mb, eb);
            chk("done_bp", done, 0);
        end
        ready = 1'b1;
        step();
        chk("done", done, 1);
        chk("valid_clr", mat_valid, 0);
        chk("busy_idle", busy, 0);
        chk("ena_no_restart", ena, 0);
        chk("mat_a_kept", ma, ea);
        chk("ena_cycles", ena_cycles - e0, 4);
        ready = 1'b0;
        start = 1'b0;
    endtask

    initial begin
        int d0;
        logic [31:0] keep_a;
        for (int i = 0; i < 8; i++) begin
            rom_a[i] = 8'h10 + 8'(i);
            rom_b[i] = 8'h20 + 8'(i);
        end

        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_ena", ena, 0);
        chk("rst_addr", addr, 0);
        chk("rst_mat_a", ma, 0);
        chk("rst_mat_b", mb, 0);
        chk("rst_valid", mat_valid, 0);
        chk("rst_done", done, 0);
        rstn = 1'b1;
        step();

        chk("pack_bank0", pack_a(0), 32'h13121110);
        do_load(0, 0, 0);
        step();
        chk("done_pulse", done, 0);

        chk("pack_bank1", pack_b(1), 32'h27262524);
        do_load(1, 10, 0);
        step();

        d0 = done_cnt;
        do_load(0, 3, 1);
        step();
        step();
        step();
        chk("single_done", done_cnt - d0, 1);
        chk("no_second_valid", mat_valid, 0);
        chk("no_extra_ena", ena, 0);

        // Reset two edges into a bank-1 load.
        start = 1'b1;
        bank  = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rstn = 1'b0;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ena", ena, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_mat_a", ma, 0);
        chk("mid_rst_mat_b", mb, 0);
        chk("mid_rst_valid", mat_valid, 0);
        rstn = 1'b1;
        step();
        step();
        chk("stale_beat_ignored", ma, 0);
        do_load(0, 0, 0);

        do_load(0, 0, 1);
        chk("b2b_first_a", ma, 32'h13121110);
        do_load(1, 0, 1);
        chk("b2b_second_a", ma, 32'h17161514);
        step();

        keep_a = ma;
        spur = 1'b1;
        step();
        spur = 1'b0;
        chk("spur_mat_a", ma, keep_a);
        chk("spur_valid", mat_valid, 0);
        chk("spur_busy", busy, 0);
        step();
        do_load(0, 0, 0);
        step();

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 8; i++) begin
                rom_a[i] = 8'($urandom);
                rom_b[i] = 8'($urandom);
            end
            if ($urandom_range(0, 1) == 1) begin
                keep_a = ma;
                spur = 1'b1;
                step();
                spur = 1'b0;
                chk("rnd_spur", ma, keep_a);
            end
            do_load(1'($urandom_range(0, 1)), int'($urandom_range(0, 4)),
                    1'($urandom_range(0, 1)));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
